// File: rtl/bsg_gateway_run_monitor_pkg.sv
// Shared types and helpers for the gateway run monitor: FSM state encoding and
// a width helper that never returns zero.
package bsg_gateway_run_monitor_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RUN     = 3'd1,
        DRAIN   = 3'd2,
        FINISH  = 3'd3,
        TIMEOUT = 3'd4
    } run_state_e;

    // Ceiling log2 clamped to at least one bit so counters never collapse to zero width.
    function automatic int safe_clog2(input int value);
        if (value <= 1) begin
            return 1;
        end else begin
            return $clog2(value);
        end
    endfunction

endpackage

// File: rtl/bsg_gateway_run_monitor_sat_ctr.sv
// Saturating up-counter with synchronous clear and count enable; holds at all-ones.
module bsg_gateway_run_monitor_sat_ctr #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_r_o
);

    logic [width_p-1:0] count_r;

    // Count register: clear wins over enable, increment stops at all-ones.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_r <= {width_p{1'b0}};
        end else if (clear_i) begin
            count_r <= {width_p{1'b0}};
        end else if (en_i && !(&count_r)) begin
            count_r <= count_r + {{(width_p-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign count_r_o = count_r;

endmodule

// File: rtl/bsg_gateway_run_monitor.sv
// Gateway-side run controller: arms on start, collects sticky per-node done flags,
// counts run cycles, applies an optional watchdog and signals finish after a drain period.
module bsg_gateway_run_monitor
    import bsg_gateway_run_monitor_pkg::*;
#(
    parameter int nodes_p          = 1,
    parameter int ctr_width_p      = 32,
    parameter int timeout_cycles_p = 0,
    parameter int drain_cycles_p   = 64
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   start_i,
    input  logic [nodes_p-1:0]     node_en_i,
    input  logic [nodes_p-1:0]     done_i,
    output logic                   busy_o,
    output logic [nodes_p-1:0]     done_mask_r_o,
    output logic                   all_done_o,
    output logic                   finish_o,
    output logic                   timeout_o,
    output logic [ctr_width_p-1:0] cycles_r_o,
    output logic [ctr_width_p-1:0] first_done_cycle_r_o,
    output logic [ctr_width_p-1:0] last_done_cycle_r_o
);

    localparam int drain_width_lp = safe_clog2(drain_cycles_p + 1);
    localparam logic [drain_width_lp-1:0] drain_load_lp =
        drain_width_lp'((drain_cycles_p > 0) ? drain_cycles_p - 1 : 0);
    localparam logic [ctr_width_p-1:0] timeout_last_lp =
        ctr_width_p'((timeout_cycles_p > 0) ? timeout_cycles_p - 1 : 0);
    localparam logic watchdog_en_lp = (timeout_cycles_p != 0);
    localparam logic drain_skip_lp  = (drain_cycles_p == 0);

    run_state_e                state_r, state_n_s;
    logic [nodes_p-1:0]        en_mask_r, done_mask_r, mask_n_s;
    logic [ctr_width_p-1:0]    first_r, last_r, cycles_s;
    logic [drain_width_lp-1:0] drain_ctr_r;
    logic                      start_ok_s, complete_s, first_hit_s, ctr_en_s;
    logic                      busy_r, all_done_r, finish_r, timeout_r;

    assign mask_n_s    = done_mask_r | (done_i & en_mask_r);
    assign complete_s  = &(mask_n_s | ~en_mask_r);
    assign first_hit_s = (done_mask_r == {nodes_p{1'b0}}) && (mask_n_s != {nodes_p{1'b0}});

    // Next-state logic; the cycle that leaves RUN does not advance the run counter.
    always_comb begin
        state_n_s  = state_r;
        start_ok_s = 1'b0;
        case (state_r)
            IDLE, FINISH, TIMEOUT: begin
                if (start_i) begin
                    state_n_s  = RUN;
                    start_ok_s = 1'b1;
                end else begin
                    state_n_s  = state_r;
                end
            end
            RUN: begin
                if (complete_s) begin
                    state_n_s = drain_skip_lp ? FINISH : DRAIN;
                end else if (watchdog_en_lp && (cycles_s == timeout_last_lp)) begin
                    state_n_s = TIMEOUT;
                end else begin
                    state_n_s = RUN;
                end
            end
            DRAIN: begin
                if (drain_ctr_r == {drain_width_lp{1'b0}}) begin
                    state_n_s = FINISH;
                end else begin
                    state_n_s = DRAIN;
                end
            end
            default: state_n_s = IDLE;
        endcase
    end

    assign ctr_en_s = (state_r == RUN) && (state_n_s == RUN);

    bsg_gateway_run_monitor_sat_ctr #(.width_p(ctr_width_p)) cycle_ctr (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .clear_i   (start_ok_s),
        .en_i      (ctr_en_s),
        .count_r_o (cycles_s)
    );

    // State register plus status flags decoded from the next state so they track it exactly.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r    <= IDLE;
            busy_r     <= 1'b0;
            all_done_r <= 1'b0;
            finish_r   <= 1'b0;
            timeout_r  <= 1'b0;
        end else begin
            state_r    <= state_n_s;
            busy_r     <= (state_n_s == RUN)    || (state_n_s == DRAIN);
            all_done_r <= (state_n_s == DRAIN)  || (state_n_s == FINISH);
            finish_r   <= (state_n_s == FINISH) || (state_n_s == TIMEOUT);
            timeout_r  <= (state_n_s == TIMEOUT);
        end
    end

    // Enable mask, sticky done flags and completion timestamps.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            en_mask_r   <= {nodes_p{1'b0}};
            done_mask_r <= {nodes_p{1'b0}};
            first_r     <= {ctr_width_p{1'b0}};
            last_r      <= {ctr_width_p{1'b0}};
        end else if (start_ok_s) begin
            en_mask_r   <= node_en_i;
            done_mask_r <= {nodes_p{1'b0}};
            first_r     <= {ctr_width_p{1'b0}};
            last_r      <= {ctr_width_p{1'b0}};
        end else if (state_r == RUN) begin
            done_mask_r <= mask_n_s;
            if (first_hit_s) begin
                first_r <= cycles_s;
            end
            if (complete_s) begin
                last_r <= cycles_s;
            end
        end
    end

    // Drain countdown, loaded on entry so DRAIN lasts exactly drain_cycles_p cycles.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drain_ctr_r <= {drain_width_lp{1'b0}};
        end else if ((state_r != DRAIN) && (state_n_s == DRAIN)) begin
            drain_ctr_r <= drain_load_lp;
        end else if ((state_r == DRAIN) && (drain_ctr_r != {drain_width_lp{1'b0}})) begin
            drain_ctr_r <= drain_ctr_r - {{(drain_width_lp-1){1'b0}}, 1'b1};
        end else begin
            drain_ctr_r <= drain_ctr_r;
        end
    end

    assign busy_o               = busy_r;
    assign done_mask_r_o        = done_mask_r;
    assign all_done_o           = all_done_r;
    assign finish_o             = finish_r;
    assign timeout_o            = timeout_r;
    assign cycles_r_o           = cycles_s;
    assign first_done_cycle_r_o = first_r;
    assign last_done_cycle_r_o  = last_r;

endmodule
